// File: rtl/servo_pkg.sv
// Shared servo pulse constants and FSM encoding, common to the drive PWM generator
// and the pulse decoder so both ends agree on the width <-> speed mapping.
package servo_pkg;

  localparam int SERVO_CENTER_US = 1500;
  localparam int SERVO_MIN_US    = 1000;
  localparam int SERVO_MAX_US    = 2000;
  localparam int US_PER_LSB      = 8;
  localparam int LSB_SHIFT       = $clog2(US_PER_LSB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } servo_state_t;

  // Absolute distance of a measured width from a reference width.
  function automatic logic [11:0] width_offset(input logic [11:0] w, input logic [11:0] c);
    return (w > c) ? (w - c) : (c - w);
  endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer plus edge-detect flop for an asynchronous pulse input,
// producing single-cycle rise/fall strobes in the clk domain.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_reg;

  // Flops reset high so a line already high at reset release does not look like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[1:0], din};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo pulse receiver: measures high time and frame period at 1 us resolution and
// recovers the signed speed command (magnitude + direction) for one wheel.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int CYC_PER_US  = 100,
  parameter int MIN_US      = SERVO_MIN_US,
  parameter int MAX_US      = SERVO_MAX_US,
  parameter int CENTER_US   = SERVO_CENTER_US,
  parameter int DEADBAND_US = 8,
  parameter int TIMEOUT_US  = 25000,
  parameter int SPEED_W     = 6
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic               pulse_in,
  output logic [11:0]        width_us,
  output logic [14:0]        period_us,
  output logic [SPEED_W-1:0] speed,
  output logic               dir,
  output logic               frame_valid,
  output logic               range_err,
  output logic               signal_lost
);

  localparam int                 PRESC_W    = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYC_PER_US - 1);
  localparam logic [11:0]        HI_MAX     = 12'hFFF;
  localparam logic [14:0]        CNT_MAX    = 15'h7FFF;
  localparam logic [11:0]        SPEED_MAX  = 12'((1 << SPEED_W) - 1);

  logic rise;
  logic fall;

  pulse_sync_edge u_sync (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .din   (pulse_in),
    .rise  (rise),
    .fall  (fall)
  );

  servo_state_t       state_reg,  state_next;
  logic [PRESC_W-1:0] presc_reg,  presc_next;
  logic [11:0]        hi_cnt_reg, hi_cnt_next;
  logic [14:0]        lo_cnt_reg, lo_cnt_next;
  logic [14:0]        age_reg,    age_next;
  logic [11:0]        width_reg,  width_next;
  logic [14:0]        period_reg, period_next;
  logic [SPEED_W-1:0] speed_reg,  speed_next;
  logic               dir_reg,    dir_next;
  logic               fv_reg,     fv_next;
  logic               range_reg,  range_next;
  logic               lost_reg,   lost_next;

  logic               us_tick;
  logic [11:0]        hi_inc;
  logic [14:0]        lo_inc;
  logic [14:0]        age_inc;
  logic [15:0]        period_sum;
  logic [14:0]        period_calc;
  logic [11:0]        offset;
  logic [11:0]        code;
  logic [SPEED_W-1:0] speed_calc;
  logic               dir_calc;
  logic               range_calc;
  logic               timed_out;

  // Prescaler realigns to each rising edge so widths are counted from the edge itself.
  assign us_tick    = (presc_reg == PRESC_LAST);
  assign presc_next = (rise || us_tick) ? '0 : presc_reg + 1'b1;

  assign hi_inc  = (us_tick && hi_cnt_reg != HI_MAX)  ? hi_cnt_reg + 12'd1 : hi_cnt_reg;
  assign lo_inc  = (us_tick && lo_cnt_reg != CNT_MAX) ? lo_cnt_reg + 15'd1 : lo_cnt_reg;
  assign age_inc = (us_tick && age_reg != CNT_MAX)    ? age_reg + 15'd1    : age_reg;

  // The tick coinciding with the closing rise still belongs to this frame's low phase.
  assign period_sum  = {4'b0000, hi_cnt_reg} + {1'b0, lo_inc};
  assign period_calc = period_sum[15] ? CNT_MAX : period_sum[14:0];

  // Timeout uses a separate age count because hi_cnt saturates and would hide a stuck-high line.
  assign timed_out = (age_reg >= 15'(TIMEOUT_US));

  always_comb begin
    offset     = width_offset(hi_cnt_reg, 12'(CENTER_US));
    code       = offset >> LSB_SHIFT;
    dir_calc   = (hi_cnt_reg > 12'(CENTER_US));
    speed_calc = '0;
    range_calc = (hi_cnt_reg < 12'(MIN_US)) || (hi_cnt_reg > 12'(MAX_US));
    if (offset < 12'(DEADBAND_US)) begin
      dir_calc = 1'b0;
    end else if (code > SPEED_MAX) begin
      speed_calc = SPEED_MAX[SPEED_W-1:0];
    end else begin
      speed_calc = code[SPEED_W-1:0];
    end
  end

  always_comb begin
    state_next  = state_reg;
    hi_cnt_next = hi_cnt_reg;
    lo_cnt_next = lo_cnt_reg;
    age_next    = age_reg;
    width_next  = width_reg;
    period_next = period_reg;
    speed_next  = speed_reg;
    dir_next    = dir_reg;
    fv_next     = 1'b0;
    range_next  = range_reg;
    lost_next   = lost_reg;

    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next  = HIGH;
          hi_cnt_next = '0;
          lo_cnt_next = '0;
          age_next    = '0;
        end
      end
      HIGH: begin
        if (timed_out) begin
          state_next = IDLE;
          lost_next  = 1'b1;
          speed_next = '0;
          dir_next   = 1'b0;
        end else begin
          hi_cnt_next = hi_inc;
          age_next    = age_inc;
          if (fall) begin
            state_next = LOW;
          end
        end
      end
      LOW: begin
        if (rise) begin
          state_next  = HIGH;
          hi_cnt_next = '0;
          lo_cnt_next = '0;
          age_next    = '0;
          width_next  = hi_cnt_reg;
          period_next = period_calc;
          speed_next  = speed_calc;
          dir_next    = dir_calc;
          range_next  = range_calc;
          fv_next     = 1'b1;
          lost_next   = 1'b0;
        end else if (timed_out) begin
          state_next = IDLE;
          lost_next  = 1'b1;
          speed_next = '0;
          dir_next   = 1'b0;
        end else begin
          lo_cnt_next = lo_inc;
          age_next    = age_inc;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_reg  <= IDLE;
      presc_reg  <= '0;
      hi_cnt_reg <= '0;
      lo_cnt_reg <= '0;
      age_reg    <= '0;
      width_reg  <= '0;
      period_reg <= '0;
      speed_reg  <= '0;
      dir_reg    <= 1'b0;
      fv_reg     <= 1'b0;
      range_reg  <= 1'b0;
      lost_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      hi_cnt_reg <= hi_cnt_next;
      lo_cnt_reg <= lo_cnt_next;
      age_reg    <= age_next;
      width_reg  <= width_next;
      period_reg <= period_next;
      speed_reg  <= speed_next;
      dir_reg    <= dir_next;
      fv_reg     <= fv_next;
      range_reg  <= range_next;
      lost_reg   <= lost_next;
    end
  end

  assign width_us    = width_reg;
  assign period_us   = period_reg;
  assign speed       = speed_reg;
  assign dir         = dir_reg;
  assign frame_valid = fv_reg;
  assign range_err   = range_reg;
  assign signal_lost = lost_reg;

endmodule
